// File: rtl/int_regs_pkg.sv
// Shared register map for the interrupt conditioner and the interrupt controller
// it feeds, plus the conditioner's per-line register reset values.
package int_regs_pkg;

    // Conditioner word addresses
    localparam int unsigned ADDR_EDGE    = 0;
    localparam int unsigned ADDR_POL     = 1;
    localparam int unsigned ADDR_FILT_EN = 2;
    localparam int unsigned ADDR_RAW     = 3;

    // Interrupt controller word addresses
    localparam int unsigned ADDR_MER = 0;
    localparam int unsigned ADDR_IER = 1;
    localparam int unsigned ADDR_IAR = 2;
    localparam int unsigned ADDR_IPR = 3;

    // Per-line reset values, replicated across INT_NUM lines at the top level
    localparam logic EDGE_RST_BIT    = 1'b0;  // level mode
    localparam logic POL_RST_BIT     = 1'b1;  // rising edge / active-high
    localparam logic FILT_EN_RST_BIT = 1'b0;  // filter bypassed

endpackage

// File: rtl/int_line_cond.sv
// One interrupt line: 2-flop synchroniser, optional glitch filter, and a
// level/edge detector with programmable polarity driving a registered int_o.
module int_line_cond
    import int_regs_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic pol_i,
    input  logic filt_en_i,
    output logic filt_o,
    output logic int_o
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
    logic             filt_q,  filt_d;
    logic             prev_q,  prev_d;
    logic             int_q,   int_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next state for the whole line pipeline
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sync0_d = irq_i;
        sync1_d = sync0_q;
        filt_d  = filt_q;
        cnt_d   = '0;

        if (!filt_en_i) begin
            filt_d = sync1_q;
        end else if (sync1_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Mismatch has been stable long enough: accept it
            filt_d = sync1_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        prev_d = filt_q;

        // Edges come only from filt vs prev, so config writes cannot fake a pulse
        if (edge_mode_i) begin
            int_d = pol_i ? (filt_q & ~prev_q) : (~filt_q & prev_q);
        end else begin
            int_d = pol_i ? filt_q : ~filt_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-high to match the surrounding codebase.
        if (reset) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            filt_q  <= 1'b0;
            prev_q  <= 1'b0;
            int_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            int_q   <= int_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign int_o  = int_q;

endmodule

// File: rtl/int_src_cond.sv
// Interrupt source conditioner: wishbone config registers plus INT_NUM
// independent line conditioners feeding the interrupt controller's int_i.
module int_src_cond
    import int_regs_pkg::*;
#(
    parameter int unsigned INT_NUM       = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SEL_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sa_dat_i,
    input  logic [SEL_WIDTH-1:0]  sa_sel_i,
    input  logic [ADDR_WIDTH-1:0] sa_addr_i,
    input  logic                  sa_stb_i,
    input  logic                  sa_we_i,
    output logic [DATA_WIDTH-1:0] sa_dat_o,
    output logic                  sa_ack_o,
    input  logic [INT_NUM-1:0]    irq_i,
    output logic [INT_NUM-1:0]    int_o
);

    logic [INT_NUM-1:0]    edge_mode_q, edge_mode_d;
    logic [INT_NUM-1:0]    pol_q,       pol_d;
    logic [INT_NUM-1:0]    filt_en_q,   filt_en_d;
    logic [DATA_WIDTH-1:0] dat_q,       dat_d;
    logic                  ack_q,       ack_d;
    logic [INT_NUM-1:0]    raw;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic                  rd_en;
    logic                  bus_unused;

    // Byte selects are ignored; data bits above INT_NUM are not stored
    assign bus_unused = ^{sa_sel_i, sa_dat_i};

    assign wr_en = sa_stb_i &  sa_we_i & ~ack_q;
    assign rd_en = sa_stb_i & ~sa_we_i & ~ack_q;

    // Read mux over the register map; unmapped words read zero
    always_comb begin
        rd_data = '0;
        case (sa_addr_i)
            ADDR_WIDTH'(ADDR_EDGE):    rd_data[INT_NUM-1:0] = edge_mode_q;
            ADDR_WIDTH'(ADDR_POL):     rd_data[INT_NUM-1:0] = pol_q;
            ADDR_WIDTH'(ADDR_FILT_EN): rd_data[INT_NUM-1:0] = filt_en_q;
            ADDR_WIDTH'(ADDR_RAW):     rd_data[INT_NUM-1:0] = raw;
            default:                   rd_data = '0;
        endcase
    end

    // Register writes, read-data capture and the two-cycle acknowledge
    always_comb begin
        edge_mode_d = edge_mode_q;
        pol_d       = pol_q;
        filt_en_d   = filt_en_q;
        ack_d       = sa_stb_i & ~ack_q;
        dat_d       = rd_en ? rd_data : dat_q;

        if (wr_en) begin
            case (sa_addr_i)
                ADDR_WIDTH'(ADDR_EDGE):    edge_mode_d = sa_dat_i[INT_NUM-1:0];
                ADDR_WIDTH'(ADDR_POL):     pol_d       = sa_dat_i[INT_NUM-1:0];
                ADDR_WIDTH'(ADDR_FILT_EN): filt_en_d   = sa_dat_i[INT_NUM-1:0];
                default:                   ;  // RAW and unmapped words are read-only
            endcase
        end
    end

    // Config and bus registers
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_mode_q <= {INT_NUM{EDGE_RST_BIT}};
            pol_q       <= {INT_NUM{POL_RST_BIT}};
            filt_en_q   <= {INT_NUM{FILT_EN_RST_BIT}};
            dat_q       <= '0;
            ack_q       <= 1'b0;
        end else begin
            edge_mode_q <= edge_mode_d;
            pol_q       <= pol_d;
            filt_en_q   <= filt_en_d;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
        end
    end

    assign sa_dat_o = dat_q;
    assign sa_ack_o = ack_q;

    for (genvar i = 0; i < INT_NUM; i++) begin : g_line
        int_line_cond #(
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_line (
            .clk        (clk),
            .reset      (reset),
            .irq_i      (irq_i[i]),
            .edge_mode_i(edge_mode_q[i]),
            .pol_i      (pol_q[i]),
            .filt_en_i  (filt_en_q[i]),
            .filt_o     (raw[i]),
            .int_o      (int_o[i])
        );
    end

endmodule

// File: tb/tb_int_src_cond.sv
// Directed bench for int_src_cond: latency, polarity, filtering, config
// writes, bus read-back and mid-operation reset.
module tb_int_src_cond;

    localparam int unsigned INT_NUM = 4;
    localparam int unsigned DW      = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] sa_dat_i;
    logic [3:0]    sa_sel_i;
    logic [2:0]    sa_addr_i;
    logic          sa_stb_i;
    logic          sa_we_i;
    logic [DW-1:0] sa_dat_o;
    logic          sa_ack_o;
    logic [3:0]    irq_i;
    logic [3:0]    int_o;

    int n_cmp = 0;
    int n_err = 0;

    int_src_cond #(
        .INT_NUM(INT_NUM), .DATA_WIDTH(DW), .SEL_WIDTH(4),
        .ADDR_WIDTH(3), .FILTER_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .sa_dat_i(sa_dat_i), .sa_sel_i(sa_sel_i),
        .sa_addr_i(sa_addr_i), .sa_stb_i(sa_stb_i), .sa_we_i(sa_we_i),
        .sa_dat_o(sa_dat_o), .sa_ack_o(sa_ack_o), .irq_i(irq_i), .int_o(int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge for sampling/driving
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
        sa_addr_i = addr; sa_dat_i = data; sa_we_i = 1'b1; sa_stb_i = 1'b1;
        tick();
        check("wr_ack_hi", {31'd0, sa_ack_o}, 32'd1);
        sa_stb_i = 1'b0; sa_we_i = 1'b0;
        tick();
        check("wr_ack_lo", {31'd0, sa_ack_o}, 32'd0);
    endtask

    task automatic wb_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        sa_addr_i = addr; sa_we_i = 1'b0; sa_stb_i = 1'b1;
        tick();
        check("rd_ack_hi", {31'd0, sa_ack_o}, 32'd1);
        check(tag, sa_dat_o, exp);
        sa_stb_i = 1'b0;
        tick();
        check("rd_ack_lo", {31'd0, sa_ack_o}, 32'd0);
    endtask

    initial begin
        int pulses;
        int doubles;
        logic last;
        logic seen;

        reset = 1'b1; sa_dat_i = '0; sa_sel_i = 4'hF; sa_addr_i = '0;
        sa_stb_i = 1'b0; sa_we_i = 1'b0; irq_i = '0;
        tick(2);
        check("rst_int_o", {28'd0, int_o}, 32'd0);
        check("rst_ack", {31'd0, sa_ack_o}, 32'd0);
        check("rst_dat", sa_dat_o, 32'd0);
        reset = 1'b0;
        tick();
        wb_read(3'd1, 32'hF, "rst_pol");
        wb_read(3'd0, 32'h0, "rst_edge");

        // Lines 0,1 edge mode; line 1 falling edge
        wb_write(3'd0, 32'h3);
        wb_write(3'd1, 32'hD);

        // Test 1: rising edge, pulse on 4th edge, 1 cycle wide
        irq_i[0] = 1'b1;
        tick(3); check("t1_edge3", {28'd0, int_o}, 32'h0);
        tick();  check("t1_edge4", {28'd0, int_o}, 32'h1);
        tick();  check("t1_edge5", {28'd0, int_o}, 32'h0);

        // Test 2: falling edge mode ignores the rise, pulses on the fall
        irq_i[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); seen |= int_o[1]; end
        check("t2_rise_nopulse", {31'd0, seen}, 32'd0);
        irq_i[1] = 1'b0;
        tick(3); check("t2_edge3", {28'd0, int_o}, 32'h0);
        tick();  check("t2_edge4", {28'd0, int_o}, 32'h2);
        tick();  check("t2_edge5", {28'd0, int_o}, 32'h0);

        // Toggle every cycle, filter off: a pulse every 2 cycles, none merged
        irq_i[0] = 1'b0;
        tick(6);
        pulses = 0; doubles = 0; last = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) irq_i[0] = ~irq_i[0];
            tick();
            if (int_o[0]) pulses++;
            if (int_o[0] && last) doubles++;
            last = int_o[0];
        end
        check("tog_pulses", pulses, 32'd4);
        check("tog_merged", doubles, 32'd0);

        // Test 4: level mode line 3, then clear POL[3]
        irq_i[3] = 1'b1;
        tick(4);
        check("t4_level_hi", {28'd0, int_o}, 32'h8);
        sa_addr_i = 3'd1; sa_dat_i = 32'h5; sa_we_i = 1'b1; sa_stb_i = 1'b1;
        tick();
        check("t4_write_edge", {28'd0, int_o}, 32'h8);
        sa_stb_i = 1'b0; sa_we_i = 1'b0;
        tick();
        check("t4_next_edge", {28'd0, int_o}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); seen |= |int_o; end
        check("t4_no_pulse", {31'd0, seen}, 32'd0);

        // Test 3: filter on line 2 (level, active-high)
        wb_write(3'd2, 32'h4);
        irq_i[2] = 1'b1;
        tick(3);
        irq_i[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); seen |= int_o[2]; end
        check("t3_glitch", {31'd0, seen}, 32'd0);
        irq_i[2] = 1'b1;
        tick(6); check("t3_edge6", {28'd0, int_o}, 32'h0);
        tick();  check("t3_edge7", {28'd0, int_o}, 32'h4);
        wb_read(3'd3, 32'hC, "t3_raw");

        // Test 5: read-back and read-only words
        wb_write(3'd0, 32'hA);
        wb_read(3'd0, 32'h0000000A, "t5_edge");
        wb_read(3'd5, 32'h0, "t5_addr5");
        wb_write(3'd3, 32'hF);
        wb_read(3'd3, 32'hC, "t5_raw_ro");
        wb_read(3'd2, 32'h4, "t5_filt_en");

        // Test 6: reset during a filter count on line 2
        irq_i[2] = 1'b0;
        tick(4);
        check("t6_cnt_mid", {29'd0, dut.g_line[2].u_line.cnt_q}, 32'd2);
        reset = 1'b1;
        tick();
        check("t6_int_o", {28'd0, int_o}, 32'h0);
        check("t6_cnt", {29'd0, dut.g_line[2].u_line.cnt_q}, 32'd0);
        check("t6_filt", {31'd0, dut.g_line[2].u_line.filt_q}, 32'd0);
        check("t6_ack", {31'd0, sa_ack_o}, 32'd0);
        check("t6_dat", sa_dat_o, 32'd0);
        reset = 1'b0;
        wb_read(3'd0, 32'h0, "t6_edge");
        wb_read(3'd1, 32'hF, "t6_pol");
        wb_read(3'd2, 32'h0, "t6_filt_en");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
